// File: rtl/sd_pkg.sv
// Shared definitions for the SD command engine: response-type encodings,
// FSM state enum, frame geometry and the serial CRC7 step function.
package sd_pkg;

  // Full command/response frame length on the CMD line
  localparam int unsigned FRAME_LEN = 48;
  // Bits covered by the CRC7 (start .. end of argument)
  localparam int unsigned CRC_SPAN  = 40;
  // x^7 + x^3 + 1, implicit x^7 term dropped
  localparam logic [6:0]  CRC7_POLY = 7'h09;

  typedef enum logic [1:0] {
    RESP_NONE      = 2'd0,
    RESP_R48       = 2'd1,
    RESP_R48_NOCRC = 2'd2,
    RESP_RSVD      = 2'd3
  } sd_resp_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_RESP = 3'd2,
    RECV      = 3'd3,
    GAP       = 3'd4,
    DONE      = 3'd5
  } sd_state_e;

  // One serial CRC7 step, MSB-first data
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator with synchronous clear and bit enable.
// Ports:
//   clk_i, rst_i : clock, async active-high reset
//   clr_i        : reset accumulator to 0 (wins over en_i)
//   en_i, din_i  : fold din_i into the CRC when en_i is high
//   crc_o        : current CRC7 value
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       din_i,
  output logic [6:0] crc_o
);

  logic [6:0] r_crc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_crc <= 7'h00;
    end else if (clr_i) begin
      r_crc <= 7'h00;
    end else if (en_i) begin
      r_crc <= crc7_step(r_crc, din_i);
    end
  end

  assign crc_o = r_crc;

endmodule

// File: rtl/sd_cmd_engine.sv
// SD card CMD-line engine: serialises a 48-bit command frame, optionally
// collects a 48-bit response, then supplies 8 idle sdclk cycles.
// Optional feature: define SD_CMD_RESP_CRC_EN to check CRC7 of R1/R7-style
// responses (resp_type 1); otherwise only the stop bit is checked.
// Ports:
//   clk_i, rst_i                 : system clock, async active-high reset
//   start_i, cmd_idx_i, arg_i,
//   resp_type_i                  : command request (accepted when idle)
//   busy_o, done_o               : in-progress flag, one-cycle completion pulse
//   resp_o, resp_idx_o           : last received response payload / index
//   timeout_o, crc_err_o         : status of the last command
//   sdclk_o, sdcmd_o, sdcmd_oe_o : card clock and CMD line drive
//   sdcmd_i                      : CMD line sample
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned RESP_TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [5:0]  cmd_idx_i,
  input  logic [31:0] arg_i,
  input  logic [1:0]  resp_type_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] resp_o,
  output logic [5:0]  resp_idx_o,
  output logic        timeout_o,
  output logic        crc_err_o,
  output logic        sdclk_o,
  output logic        sdcmd_o,
  output logic        sdcmd_oe_o,
  input  logic        sdcmd_i
);

  localparam int unsigned DIV_W = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
  localparam int unsigned TO_W  = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT + 1) : 1;
  localparam int unsigned GAP_CYCLES = 8;

  sd_state_e        r_state;
  sd_resp_e         r_resp_type;
  logic [DIV_W-1:0] r_div;
  logic             r_sdclk;
  logic [5:0]       r_bit_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [39:0]      r_tx_sh;
  logic [44:0]      r_rx_sh;

  logic       w_active;
  logic       w_tick;
  logic       w_rise;
  logic       w_fall;
  logic       w_want_resp;
  logic       w_tx_bit;
  logic [2:0] w_crc_sel;
  logic [6:0] w_tx_crc;
  logic       w_tx_crc_clr;
  logic       w_tx_crc_en;
  logic       w_rx_crc_bad;

  // sdclk edge events: a tick flips sdclk, so its current level tells the edge
  assign w_active    = (r_state != IDLE) && (r_state != DONE);
  assign w_tick      = w_active && (r_div == DIV_W'(CLK_DIV));
  assign w_rise      = w_tick && !r_sdclk;
  assign w_fall      = w_tick &&  r_sdclk;
  assign w_want_resp = (r_resp_type == RESP_R48) || (r_resp_type == RESP_R48_NOCRC);

  // Transmit CRC runs over the header bits as they leave the shifter
  assign w_tx_crc_clr = (r_state == IDLE) && start_i;
  assign w_tx_crc_en  = (r_state == SEND) && w_fall && (r_bit_cnt < 6'(CRC_SPAN));

  sd_crc7 u_tx_crc (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (w_tx_crc_clr),
    .en_i  (w_tx_crc_en),
    .din_i (r_tx_sh[39]),
    .crc_o (w_tx_crc)
  );

  // CRC bits go out MSB first: bit positions 40..46 map to crc[6..0]
  assign w_crc_sel = 3'(6'd46 - r_bit_cnt);

  // Next bit to drive: header, then CRC7, then stop bit
  always_comb begin
    w_tx_bit = 1'b1;
    if (r_bit_cnt < 6'(CRC_SPAN)) begin
      w_tx_bit = r_tx_sh[39];
    end else if (r_bit_cnt < 6'(FRAME_LEN - 1)) begin
      w_tx_bit = w_tx_crc[w_crc_sel];
    end
  end

`ifdef SD_CMD_RESP_CRC_EN
  logic       w_rx_crc_clr;
  logic       w_rx_crc_en;
  logic [6:0] w_rx_crc;

  // Leading start bit is 0 and CRC starts at 0, so it can be skipped:
  // clear on start detect, then fold the 39 bits up to the argument end.
  assign w_rx_crc_clr = (r_state == WAIT_RESP) && w_rise && !sdcmd_i;
  assign w_rx_crc_en  = (r_state == RECV) && w_rise && (r_bit_cnt < 6'(CRC_SPAN - 1));

  sd_crc7 u_rx_crc (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (w_rx_crc_clr),
    .en_i  (w_rx_crc_en),
    .din_i (sdcmd_i),
    .crc_o (w_rx_crc)
  );

  assign w_rx_crc_bad = (r_resp_type == RESP_R48) && (w_rx_crc != r_rx_sh[6:0]);
`else
  assign w_rx_crc_bad = 1'b0;
`endif

  // Main FSM, sdclk divider and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_resp_type <= RESP_NONE;
      r_div       <= '0;
      r_sdclk     <= 1'b0;
      r_bit_cnt   <= 6'd0;
      r_to_cnt    <= '0;
      r_tx_sh     <= 40'd0;
      r_rx_sh     <= 45'd0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      resp_o      <= 32'd0;
      resp_idx_o  <= 6'd0;
      timeout_o   <= 1'b0;
      crc_err_o   <= 1'b0;
      sdcmd_o     <= 1'b1;
      sdcmd_oe_o  <= 1'b0;
    end else begin
      if (w_active) begin
        if (w_tick) begin
          r_div   <= '0;
          r_sdclk <= ~r_sdclk;
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end

      case (r_state)
        IDLE: begin
          r_div   <= '0;
          r_sdclk <= 1'b0;
          done_o  <= 1'b0;
          if (start_i) begin
            r_state     <= SEND;
            r_resp_type <= sd_resp_e'(resp_type_i);
            r_tx_sh     <= {2'b01, cmd_idx_i, arg_i};
            r_bit_cnt   <= 6'd0;
            busy_o      <= 1'b1;
            timeout_o   <= 1'b0;
            crc_err_o   <= 1'b0;
            // Take the line at idle level; the start bit follows on a falling edge
            sdcmd_o     <= 1'b1;
            sdcmd_oe_o  <= 1'b1;
          end
        end

        SEND: begin
          if (w_fall) begin
            if (r_bit_cnt == 6'(FRAME_LEN)) begin
              sdcmd_o    <= 1'b1;
              sdcmd_oe_o <= 1'b0;
              r_bit_cnt  <= 6'd0;
              r_to_cnt   <= '0;
              r_state    <= w_want_resp ? WAIT_RESP : GAP;
            end else begin
              sdcmd_o   <= w_tx_bit;
              r_bit_cnt <= r_bit_cnt + 6'd1;
              if (r_bit_cnt < 6'(CRC_SPAN)) begin
                r_tx_sh <= {r_tx_sh[38:0], 1'b0};
              end
            end
          end
        end

        WAIT_RESP: begin
          if (w_rise) begin
            if (!sdcmd_i) begin
              r_state   <= RECV;
              r_bit_cnt <= 6'd0;
            end else if (r_to_cnt == TO_W'(RESP_TIMEOUT - 1)) begin
              timeout_o <= 1'b1;
              r_bit_cnt <= 6'd0;
              r_state   <= GAP;
            end else if (r_to_cnt != '1) begin
              r_to_cnt <= r_to_cnt + TO_W'(1);
            end
          end
        end

        RECV: begin
          if (w_rise) begin
            r_rx_sh <= {r_rx_sh[43:0], sdcmd_i};
            if (r_bit_cnt == 6'(FRAME_LEN - 2)) begin
              // r_rx_sh holds bits 45..1 of the response; sdcmd_i is the stop bit
              resp_idx_o <= r_rx_sh[44:39];
              resp_o     <= r_rx_sh[38:7];
              crc_err_o  <= !sdcmd_i || w_rx_crc_bad;
              r_bit_cnt  <= 6'd0;
              r_state    <= GAP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 6'd1;
            end
          end
        end

        GAP: begin
          // Count 8 rising edges; finish on the falling edge that ends the 8th cycle
          if (w_rise && (r_bit_cnt != 6'(GAP_CYCLES))) begin
            r_bit_cnt <= r_bit_cnt + 6'd1;
          end
          if (w_fall && (r_bit_cnt == 6'(GAP_CYCLES))) begin
            r_state   <= DONE;
            r_sdclk   <= 1'b0;
            r_bit_cnt <= 6'd0;
            done_o    <= 1'b1;
            busy_o    <= 1'b0;
          end
        end

        DONE: begin
          r_div   <= '0;
          r_sdclk <= 1'b0;
          done_o  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state    <= IDLE;
          busy_o     <= 1'b0;
          done_o     <= 1'b0;
          sdcmd_o    <= 1'b1;
          sdcmd_oe_o <= 1'b0;
        end
      endcase
    end
  end

  assign sdclk_o = r_sdclk;

endmodule
